motion_guard: RTL
=================

# motion_guard

Parametrised multi-channel anti-theft motion detector for the bicycle helper's mobile unit, successor to the single-pair lock detector. On `lock` it waits an arming delay, captures a baseline from every sensor channel, then raises a latched alarm when any channel deviates by at least `THRESH` for `DEBOUNCE` consecutive valid samples. It drives the active-low warning buzzer with a configurable on/off cadence and reports which channels tripped.

## Interface
- `N_CH`, 3, number of sensor channels
- `W`, 9, sample width per channel (unsigned)
- `THRESH`, 20, trip threshold on |sample − baseline|, W bits
- `DEBOUNCE`, 4, consecutive exceeding samples needed to trip (≥1)
- `ARM_DELAY`, 50_000_000, cycles between lock and baseline capture (≥1)
- `BEEP_HALF`, 50_000_000, buzzer half-period in cycles (≥1)
- `ALARM_HOLD`, 500_000_000, alarm duration before auto re-arm (used only with `GUARD_REARM_EN`)

Ports:
- `clk` in 1 — system clock
- `rst_n` in 1 — synchronous, active-low reset
- `sample` in N_CH*W — channel i at bits [i*W +: W]
- `sample_valid` in 1 — one-cycle strobe, `sample` valid this cycle
- `lock` in 1 — level, 1 = user requests guarding
- `armed` out 1 — 1 while in ARMED
- `safety` out 1 — 0 safe, 1 alarm (registered)
- `trip_mask` out N_CH — channels that had reached DEBOUNCE at trip time, latched
- `warning_bell` out 1 — buzzer, active-low

## Operation
- States: DISARMED, ARMING, ARMED, ALARM.
- DISARMED: `sample_valid` ignored. `lock`=1 → ARMING, delay counter cleared.
- ARMING: count cycles; after ARM_DELAY cycles, capture all channels on next `sample_valid` into baselines, clear debounce counters → ARMED.
- ARMED: on each `sample_valid`, per channel delta = |sample − base| computed unsigned in W bits without wrap (larger minus smaller). delta ≥ THRESH → counter +1, saturating at DEBOUNCE; else counter ← 0. Any counter reaching DEBOUNCE on this sample → ALARM; `trip_mask` ← set of channels at DEBOUNCE.
- ALARM: `safety`=1, buzzer cadence runs. `lock`=0 → DISARMED; `trip_mask` cleared, counters cleared.
- `lock`=0 in ARMING, ARMED or ALARM → DISARMED next edge, overriding every other transition (including a trip in the same cycle).
- Baselines are never updated outside the ARMING capture.

## Timing
- Reset values: state DISARMED, `armed` 0, `safety` 0, `trip_mask` 0, `warning_bell` 1, baselines 0, all counters 0.
- `lock` rising at edge k → ARMING from k+1; capture is the first `sample_valid` at or after ARMING cycle ARM_DELAY; `armed`=1 the cycle after capture.
- Trip: `sample_valid` cycle t completes debounce → `safety`, `trip_mask` high from t+1.
- Buzzer: beep counter cleared on entering ALARM; `warning_bell`=0 for BEEP_HALF cycles starting t+1, then 1 for BEEP_HALF, repeating. Outside ALARM `warning_bell`=1.
- Unlock: `lock`=0 at cycle u → all outputs at reset values from u+1 (baselines retained, irrelevant).
- `rst_n`=0 mid-operation → reset values next edge, regardless of state.

## Configuration
- `GUARD_REARM_EN` defined: ALARM counts cycles; after ALARM_HOLD cycles with `lock` still 1 → ARMING (counters and `trip_mask` cleared, `safety`=0, new baseline after ARM_DELAY). `lock`=0 still has priority.
- Undefined: ALARM latches until `lock`=0; no hold counter is built.

## Test plan
Bench: N_CH=3, W=9, THRESH=20, DEBOUNCE=3, ARM_DELAY=8, BEEP_HALF=4, ALARM_HOLD=32; `sample_valid` every 2 cycles.
- Lock with all channels at 100, then ch1=119 for 10 samples → `armed`=1, `safety` stays 0 (delta 19 < 20).
- Armed with baseline 100, ch2=80,80,80 → `safety`=1 the cycle after the third sample, `trip_mask`=3'b100, `warning_bell` 0 for 4 cycles, 1 for 4, repeating.
- ch0=130,130,100,130,130 → no trip (debounce reset); then 130 again → trip, `trip_mask`=3'b001; baseline 5 with sample 0 → delta 5, no underflow.
- `lock`=0 on the same cycle as the third exceeding sample → DISARMED next cycle, `safety` never 1, `warning_bell` stays 1.
- In ALARM, drive `rst_n`=0 for one cycle → all outputs at reset values next cycle; state DISARMED even with `lock`=1, re-arming from scratch.
- With `GUARD_REARM_EN`: trip, hold `lock`=1 → after 32 ALARM cycles `safety`=0, `trip_mask`=0, ARMING; `armed`=1 after new capture. Without the macro, `safety` stays 1 for 200 cycles.

Source files
------------

// File: rtl/motion_guard.sv
// -----------------------------------------------------------------------------
// motion_guard
// Multi-channel anti-theft motion detector. When `lock` is raised the block
// waits ARM_DELAY cycles and then captures a baseline from every channel on the
// next valid sample. While armed, it raises a latched alarm when any channel
// differs from its baseline by at least THRESH for DEBOUNCE consecutive valid
// samples. In alarm, the active-low buzzer toggles every BEEP_HALF cycles.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   sample       in   N_CH*W, channel i at bits [i*W +: W] (unsigned)
//   sample_valid in   one-cycle strobe, `sample` valid this cycle
//   lock         in   level, 1 = guarding requested
//   armed        out  1 while in ARMED
//   safety       out  0 safe, 1 alarm (registered)
//   trip_mask    out  N_CH, channels at DEBOUNCE when the alarm fired (latched)
//   warning_bell out  buzzer, active-low
//
// Build option: define GUARD_REARM_EN to leave ALARM automatically after
// ALARM_HOLD cycles and re-arm with a fresh baseline. Without it the alarm
// stays latched until `lock` drops and no hold counter exists.
// -----------------------------------------------------------------------------
module motion_guard #(
  parameter int N_CH       = 3,
  parameter int W          = 9,
  parameter int THRESH     = 20,
  parameter int DEBOUNCE   = 4,
  parameter int ARM_DELAY  = 50_000_000,
  parameter int BEEP_HALF  = 50_000_000,
  parameter int ALARM_HOLD = 500_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] sample,
  input  logic              sample_valid,
  input  logic              lock,
  output logic              armed,
  output logic              safety,
  output logic [N_CH-1:0]   trip_mask,
  output logic              warning_bell
);

  localparam int DW = $clog2(ARM_DELAY + 1);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int BW = $clog2(BEEP_HALF + 1);
  localparam logic [DW-1:0] ARM_C       = DW'(ARM_DELAY);
  localparam logic [CW-1:0] DEB_C       = CW'(DEBOUNCE);
  localparam logic [BW-1:0] BEEP_LAST_C = BW'(BEEP_HALF - 1);
  localparam logic [W-1:0]  THRESH_C    = W'(THRESH);
`ifdef GUARD_REARM_EN
  localparam int HW = $clog2(ALARM_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST_C = HW'(ALARM_HOLD - 1);
`endif

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMING   = 2'd1,
    S_ARMED    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  state_t                    r_state, w_state_next;
  logic [DW-1:0]             r_dly, w_dly_next;
  logic [N_CH-1:0][W-1:0]    r_base, w_base_next;
  logic [N_CH-1:0][CW-1:0]   r_deb, w_deb_next;
  logic [N_CH-1:0]           r_trip, w_trip_next;
  logic [BW-1:0]             r_beep, w_beep_next;
  logic                      r_bell, w_bell_next;
  logic                      r_armed, r_safety;
`ifdef GUARD_REARM_EN
  logic [HW-1:0]             r_hold, w_hold_next;
`endif

  // Per-channel deviation and debounce update for the current sample.
  logic [N_CH-1:0][CW-1:0]   w_deb_upd;
  logic [N_CH-1:0]           w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W-1:0]  w_smp;
      logic [W-1:0]  w_delta;
      logic [CW-1:0] w_inc;
      assign w_smp   = sample[gi*W +: W];
      // Larger minus smaller so the magnitude never wraps.
      assign w_delta = (w_smp >= r_base[gi]) ? (w_smp - r_base[gi])
                                             : (r_base[gi] - w_smp);
      assign w_inc   = (r_deb[gi] == DEB_C) ? DEB_C : (r_deb[gi] + 1'b1);
      assign w_deb_upd[gi] = (w_delta >= THRESH_C) ? w_inc : '0;
      assign w_hit[gi]     = (w_deb_upd[gi] == DEB_C);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_dly_next   = r_dly;
    w_base_next  = r_base;
    w_deb_next   = r_deb;
    w_trip_next  = r_trip;
    w_beep_next  = r_beep;
    w_bell_next  = 1'b1;
`ifdef GUARD_REARM_EN
    w_hold_next  = r_hold;
`endif

    case (r_state)
      S_DISARMED: begin
        if (lock) begin
          w_state_next = S_ARMING;
          w_dly_next   = '0;
        end
      end
      S_ARMING: begin
        // Counter saturates at ARM_DELAY; capture waits for the next strobe.
        if (r_dly != ARM_C) begin
          w_dly_next = r_dly + 1'b1;
        end else if (sample_valid) begin
          w_base_next  = sample;
          w_deb_next   = '0;
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_valid) begin
          w_deb_next = w_deb_upd;
          if (|w_hit) begin
            w_state_next = S_ALARM;
            w_trip_next  = w_hit;
            w_beep_next  = '0;
            w_bell_next  = 1'b0;
`ifdef GUARD_REARM_EN
            w_hold_next  = '0;
`endif
          end
        end
      end
      S_ALARM: begin
        if (r_beep == BEEP_LAST_C) begin
          w_beep_next = '0;
          w_bell_next = ~r_bell;
        end else begin
          w_beep_next = r_beep + 1'b1;
          w_bell_next = r_bell;
        end
`ifdef GUARD_REARM_EN
        if (r_hold == HOLD_LAST_C) begin
          w_state_next = S_ARMING;
          w_dly_next   = '0;
          w_deb_next   = '0;
          w_trip_next  = '0;
          w_bell_next  = 1'b1;
        end else begin
          w_hold_next = r_hold + 1'b1;
        end
`endif
      end
      default: w_state_next = S_DISARMED;
    endcase

    // Dropping lock wins over every other transition, including a trip.
    if (!lock && (r_state != S_DISARMED)) begin
      w_state_next = S_DISARMED;
      w_deb_next   = '0;
      w_trip_next  = '0;
      w_bell_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_DISARMED;
      r_dly    <= '0;
      r_base   <= '0;
      r_deb    <= '0;
      r_trip   <= '0;
      r_beep   <= '0;
      r_bell   <= 1'b1;
      r_armed  <= 1'b0;
      r_safety <= 1'b0;
`ifdef GUARD_REARM_EN
      r_hold   <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_dly    <= w_dly_next;
      r_base   <= w_base_next;
      r_deb    <= w_deb_next;
      r_trip   <= w_trip_next;
      r_beep   <= w_beep_next;
      r_bell   <= w_bell_next;
      r_armed  <= (w_state_next == S_ARMED);
      r_safety <= (w_state_next == S_ALARM);
`ifdef GUARD_REARM_EN
      r_hold   <= w_hold_next;
`endif
    end
  end

  assign armed        = r_armed;
  assign safety       = r_safety;
  assign trip_mask    = r_trip;
  assign warning_bell = r_bell;

endmodule
